// File: rtl/plot_arbiter_pkg.sv
// Shared drawing-path types and default widths for the pixel-write datapath.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
// Contents: arbiter state enum, coordinate/color width defaults, grant decode.
package draw_pkg;

    // Widths shared by the processor, ROM walker and the pixel-port arbiter.
    localparam int DRAW_X_W     = 8;
    localparam int DRAW_Y_W     = 8;
    localparam int DRAW_COLOR_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_t;

    // One-hot owner vector: bit 0 = requester 0, bit 1 = requester 1.
    function automatic logic [1:0] state_grant(input arb_state_t st);
        logic [1:0] g;
        g = 2'b00;
        if (st == ST_GNT0) g = 2'b01;
        if (st == ST_GNT1) g = 2'b10;
        return g;
    endfunction

endpackage

// File: rtl/plot_arbiter_if.sv
// Bundle of the two requester handshakes and the shared VGA pixel-write port.
// Latency: n/a (wiring only).
// Backpressure: requesters hold reqN/data until ackN; the pixel port has none.
// Modports: master = requester/VGA side (drives req/data/lock, sees ack/grant/pixel);
//           slave  = arbiter side.
interface plot_arbiter_if
    import draw_pkg::*;
#(
    parameter int X_W     = DRAW_X_W,
    parameter int Y_W     = DRAW_Y_W,
    parameter int COLOR_W = DRAW_COLOR_W
);
    logic               req0;
    logic [X_W-1:0]     x0;
    logic [Y_W-1:0]     y0;
    logic [COLOR_W-1:0] color0;
    logic               lock0;
    logic               ack0;

    logic               req1;
    logic [X_W-1:0]     x1;
    logic [Y_W-1:0]     y1;
    logic [COLOR_W-1:0] color1;
    logic               lock1;
    logic               ack1;

    logic [1:0]         grant;
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [COLOR_W-1:0] color_draw;
    logic               plot;

    modport master (
        output req0, x0, y0, color0, lock0,
        output req1, x1, y1, color1, lock1,
        input  ack0, ack1, grant, x, y, color_draw, plot
    );

    modport slave (
        input  req0, x0, y0, color0, lock0,
        input  req1, x1, y1, color1, lock1,
        output ack0, ack1, grant, x, y, color_draw, plot
    );

endinterface

// File: rtl/plot_arb_rr.sv
// Round-robin pick between two requesters, favouring the one that did not own last.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is used.
// Ports: i_req0/i_req1 requests, i_last_owner previous owner,
//        o_any = some request present, o_winner = chosen requester index.
module plot_arb_rr (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_owner,
    output logic o_any,
    output logic o_winner
);

    always_comb begin
        o_any    = i_req0 | i_req1;
        o_winner = 1'b0;
        if (i_req0 && i_req1) begin
            // Tie: hand the port to whoever did not have it last.
            o_winner = ~i_last_owner;
        end else if (i_req1) begin
            o_winner = 1'b1;
        end
    end

endmodule

// File: rtl/plot_arbiter.sv
// Shares the single VGA pixel-write port between the ROM redraw engine (0) and the CPU path (1).
// Latency: grant 1 cycle after IDLE sees a request; plot/x/y/color registered 1 cycle after ack.
// Backpressure: ackN is combinational (reqN while granted); 1 pixel/cycle while a grant is held.
// Ports: clk, reset_n (async active-low), bus (slave side of plot_arbiter_if).
module plot_arbiter
    import draw_pkg::*;
#(
    parameter int X_W       = DRAW_X_W,
    parameter int Y_W       = DRAW_Y_W,
    parameter int COLOR_W   = DRAW_COLOR_W,
    parameter int MAX_BURST = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    plot_arbiter_if.slave  bus
);

    localparam int                CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  BURST_MAX = CNT_W'(MAX_BURST);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    arb_state_t         w_peer_state;
    logic               r_last_owner;
    logic [CNT_W-1:0]   r_burst;
    logic [CNT_W-1:0]   w_burst_acc;

    logic [X_W-1:0]     r_x;
    logic [Y_W-1:0]     r_y;
    logic [COLOR_W-1:0] r_color;
    logic               r_plot;

    logic               w_ack0;
    logic               w_ack1;
    logic               w_accept;
    logic               w_owner;
    logic               w_own_req;
    logic               w_own_lock;
    logic               w_peer_req;
    logic               w_enter;
    logic               w_rr_any;
    logic               w_rr_win;

    plot_arb_rr u_rr (
        .i_req0       (bus.req0),
        .i_req1       (bus.req1),
        .i_last_owner (r_last_owner),
        .o_any        (w_rr_any),
        .o_winner     (w_rr_win)
    );

    // Owner-relative view of the requests so GNT0/GNT1 share one set of rules.
    assign w_owner      = (r_state == ST_GNT1);
    assign w_own_req    = w_owner ? bus.req1  : bus.req0;
    assign w_own_lock   = w_owner ? bus.lock1 : bus.lock0;
    assign w_peer_req   = w_owner ? bus.req0  : bus.req1;
    assign w_peer_state = w_owner ? ST_GNT0   : ST_GNT1;

    assign w_ack0   = (r_state == ST_GNT0) && bus.req0;
    assign w_ack1   = (r_state == ST_GNT1) && bus.req1;
    assign w_accept = w_ack0 | w_ack1;

    // Burst count including this cycle's acceptance, saturating so a lone
    // requester can stream forever without wrapping.
    always_comb begin
        w_burst_acc = r_burst;
        if (w_accept && (r_burst != BURST_MAX)) begin
            w_burst_acc = r_burst + CNT_W'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rr_any) begin
                    w_state_nxt = w_rr_win ? ST_GNT1 : ST_GNT0;
                end
            end
            ST_GNT0, ST_GNT1: begin
                // A held lock pins the grant; the peer starves until it drops.
                if (!w_own_lock) begin
                    if (!w_own_req) begin
                        w_state_nxt = w_peer_req ? w_peer_state : ST_IDLE;
                    end else if ((w_burst_acc == BURST_MAX) && w_peer_req) begin
                        w_state_nxt = w_peer_state;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // A fresh grant (from IDLE or a hand-over) restarts the burst window.
    assign w_enter = (w_state_nxt != r_state) && (w_state_nxt != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_last_owner <= 1'b1;
            r_burst      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_enter) begin
                r_last_owner <= (w_state_nxt == ST_GNT1);
                r_burst      <= '0;
            end else begin
                r_burst      <= w_burst_acc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_plot  <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_color <= '0;
        end else begin
            r_plot <= w_accept;
            if (w_accept) begin
                r_x     <= w_owner ? bus.x1     : bus.x0;
                r_y     <= w_owner ? bus.y1     : bus.y0;
                r_color <= w_owner ? bus.color1 : bus.color0;
            end
        end
    end

    assign bus.ack0       = w_ack0;
    assign bus.ack1       = w_ack1;
    assign bus.grant      = state_grant(r_state);
    assign bus.x          = r_x;
    assign bus.y          = r_y;
    assign bus.color_draw = r_color;
    assign bus.plot       = r_plot;

endmodule
